// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
// Operand/control stage in front of the 32-bit ALU. It holds the register bank and accepts one
// {op, rs, rt, rd} command at a time. It drives the ALU operands and waits out the ALU latency.
// It then captures the result, writes it back to rd and returns it on a valid/ready response port.
module alu_operand_sequencer #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_op,
    input  logic [RADDR_W-1:0] cmd_rs,
    input  logic [RADDR_W-1:0] cmd_rt,
    input  logic [RADDR_W-1:0] cmd_rd,
    input  logic               ld_en,
    input  logic [RADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0]  ld_data,
    output logic [DATA_W-1:0]  alu_x,
    output logic [DATA_W-1:0]  alu_y,
    output logic [3:0]         alu_s,
    input  logic [DATA_W-1:0]  alu_r,
    input  logic               alu_zflag,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [DATA_W-1:0]  res_data,
    output logic               res_zero,
    output logic               res_err,
    output logic [RADDR_W-1:0] res_rd
);

    localparam int NREGS = 2 ** RADDR_W;
    localparam int CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAPT,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_cmd_ready;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_bank [NREGS];
    logic [DATA_W-1:0]   r_alu_x;
    logic [DATA_W-1:0]   r_alu_y;
    logic [3:0]          r_alu_s;
    logic                r_res_valid;
    logic [DATA_W-1:0]   r_res_data;
    logic                r_res_zero;
    logic                r_res_err;
    logic [RADDR_W-1:0]  r_res_rd;

    logic                w_accept;
    logic                w_legal;
    logic                w_ld_we;
    logic                w_wb_we;
    logic [DATA_W-1:0]   w_rs_data;
    logic [DATA_W-1:0]   w_rt_data;

    // Ops the ALU implements; anything else is answered with an error and never reaches the ALU.
    function automatic logic f_legal(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: f_legal = 1'b1;
            default:                             f_legal = 1'b0;
        endcase
    endfunction

    assign w_accept  = cmd_valid && r_cmd_ready;
    assign w_legal   = f_legal(cmd_op);
    assign w_rs_data = (cmd_rs == '0) ? '0 : r_bank[cmd_rs];
    assign w_rt_data = (cmd_rt == '0) ? '0 : r_bank[cmd_rt];
    assign w_ld_we   = ld_en && (r_state == S_IDLE) && (ld_addr != '0);
    assign w_wb_we   = (r_state == S_CAPT) && (r_res_rd != '0);

    // State register and a registered cmd_ready, which stays low while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cmd_ready <= (w_next == S_IDLE);
        end
    end

    // Next-state decode for the IDLE -> WAIT -> CAPT -> RESP -> IDLE sequence.
    always_comb begin
        // NOTE: the next state defaults to the current one first, so no branch can infer a latch.
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_legal ? S_WAIT : S_RESP;
            S_WAIT: if (r_cnt == CNT_W'(1)) w_next = S_CAPT;
            S_CAPT: w_next = S_RESP;
            S_RESP: if (r_res_valid && res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand launch, latency count, result capture and response hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_x     <= '0;
            r_alu_y     <= '0;
            r_alu_s     <= '0;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_zero  <= 1'b0;
            r_res_err   <= 1'b0;
            r_res_rd    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_res_rd <= cmd_rd;
                        if (w_legal) begin
                            r_alu_x <= w_rs_data;
                            r_alu_y <= w_rt_data;
                            r_alu_s <= cmd_op;
                            r_cnt   <= CNT_W'(ALU_LAT);
                        end else begin
                            r_res_valid <= 1'b1;
                            r_res_err   <= 1'b1;
                            r_res_data  <= '0;
                            r_res_zero  <= 1'b0;
                        end
                    end
                end
                S_WAIT: r_cnt <= r_cnt - CNT_W'(1);
                S_CAPT: begin
                    r_res_data  <= alu_r;
                    r_res_zero  <= alu_zflag;
                    r_res_valid <= 1'b1;
                    r_res_err   <= 1'b0;
                end
                S_RESP: if (res_ready) r_res_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    // Register bank: host loads while idle, ALU writeback on the capture edge, index 0 never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every entry is reset because reset must leave the whole bank reading 0.
            for (int i = 0; i < NREGS; i++) r_bank[i] <= '0;
        end else begin
            // NOTE: non-blocking, so a command accepted on the same edge as a load reads the old value.
            if (w_ld_we) r_bank[ld_addr] <= ld_data;
            if (w_wb_we) r_bank[r_res_rd] <= alu_r;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign alu_x     = r_alu_x;
    assign alu_y     = r_alu_y;
    assign alu_s     = r_alu_s;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_zero  = r_res_zero;
    assign res_err   = r_res_err;
    assign res_rd    = r_res_rd;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer
// Directed bench for alu_operand_sequencer with a behavioural ALU of ALU_LAT registered stages.
module tb_alu_operand_sequencer;

    localparam int ALU_LAT = 1;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [4:0]  cmd_rs;
    logic [4:0]  cmd_rt;
    logic [4:0]  cmd_rd;
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [3:0]  alu_s;
    logic [31:0] alu_r;
    logic        alu_zflag;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_zero;
    logic        res_err;
    logic [4:0]  res_rd;

    int n_checks = 0;
    int n_fail   = 0;

    alu_operand_sequencer #(
        .DATA_W (32),
        .RADDR_W(5),
        .ALU_LAT(ALU_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_rs   (cmd_rs),
        .cmd_rt   (cmd_rt),
        .cmd_rd   (cmd_rd),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .alu_x    (alu_x),
        .alu_y    (alu_y),
        .alu_s    (alu_s),
        .alu_r    (alu_r),
        .alu_zflag(alu_zflag),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_zero (res_zero),
        .res_err  (res_err),
        .res_rd   (res_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural ALU.
    function automatic logic [31:0] alu_f(input logic [31:0] x, input logic [31:0] y, input logic [3:0] s);
        case (s)
            4'd0:    alu_f = x & y;
            4'd1:    alu_f = x | y;
            4'd2:    alu_f = x + y;
            4'd6:    alu_f = x - y;
            4'd7:    alu_f = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd12:   alu_f = ~(x | y);
            default: alu_f = 32'd0;
        endcase
    endfunction

    logic [31:0] alu_pipe [ALU_LAT];

    always @(posedge clk) begin
        alu_pipe[0] <= alu_f(alu_x, alu_y, alu_s);
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end

    assign alu_r     = alu_pipe[ALU_LAT-1];
    assign alu_zflag = (alu_pipe[ALU_LAT-1] == 32'd0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ld(input logic [4:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    // Issue one legal command, check latency and response, then complete the handshake.
    // Any ld_en set up by the caller shares the accept edge.
    task automatic run_cmd(input string name, input logic [3:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] exp_data, input logic exp_zero);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin tick(); n++; end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s ready: cmd_ready=%b required 1", name, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
        tick();
        cmd_valid = 1'b0; ld_en = 1'b0;
        n = 0;
        while (res_valid !== 1'b1 && n < 20) begin tick(); n++; end
        n_checks++;
        if (n != ALU_LAT + 1) begin
            n_fail++; $display("FAIL %s latency: got %0d edges required %0d", name, n, ALU_LAT + 1);
        end
        n_checks++;
        if ({res_data, res_zero, res_err, res_rd} !== {exp_data, exp_zero, 1'b0, rd}) begin
            n_fail++;
            $display("FAIL %s result: data=%h zero=%b err=%b rd=%0d required data=%h zero=%b err=0 rd=%0d",
                     name, res_data, res_zero, res_err, res_rd, exp_data, exp_zero, rd);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_checks++;
        if ({res_valid, cmd_ready} !== 2'b01) begin
            n_fail++; $display("FAIL %s handshake: res_valid=%b cmd_ready=%b required 0 1", name, res_valid, cmd_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({alu_x, alu_y, alu_s, res_valid, res_data, res_zero, res_err, res_rd, cmd_ready} !== '0) begin
            n_fail++; $display("FAIL reset outputs: x=%h y=%h s=%h rv=%b rd=%h cr=%b required all 0",
                               alu_x, alu_y, alu_s, res_valid, res_data, cmd_ready);
        end
        rst_n = 1'b1;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset release ready: cmd_ready=%b required 0", cmd_ready);
        end
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL first edge ready: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_basic();
        do_ld(5'd1, 32'd5);
        do_ld(5'd2, 32'd3);
        run_cmd("add_r1_r2", 4'd2, 5'd1, 5'd2, 5'd3, 32'd8, 1'b0);
        run_cmd("or_r3_r0", 4'd1, 5'd3, 5'd0, 5'd4, 32'd8, 1'b0);
    endtask

    task automatic test_alu_ops();
        run_cmd("sub_r1_r1", 4'd6, 5'd1, 5'd1, 5'd5, 32'd0, 1'b1);
        run_cmd("slt_r2_r1", 4'd7, 5'd2, 5'd1, 5'd6, 32'd1, 1'b0);
        run_cmd("nor_r0_r0", 4'd12, 5'd0, 5'd0, 5'd7, 32'hFFFF_FFFF, 1'b0);
        run_cmd("and_r4_r1", 4'd0, 5'd4, 5'd1, 5'd8, 32'd0, 1'b1);
    endtask

    task automatic test_r0();
        run_cmd("add_to_r0", 4'd2, 5'd1, 5'd2, 5'd0, 32'd8, 1'b0);
        run_cmd("or_r0_r0", 4'd1, 5'd0, 5'd0, 5'd8, 32'd0, 1'b1);
    endtask

    task automatic test_illegal();
        cmd_valid = 1'b1; cmd_op = 4'd3; cmd_rs = 5'd1; cmd_rt = 5'd2; cmd_rd = 5'd1;
        tick();
        cmd_valid = 1'b0;
        tick();
        n_checks++;
        if ({res_valid, res_err, res_data, res_zero, res_rd} !== {1'b1, 1'b1, 32'd0, 1'b0, 5'd1}) begin
            n_fail++; $display("FAIL illegal response: rv=%b err=%b data=%h zero=%b rd=%0d required 1 1 0 0 1",
                               res_valid, res_err, res_data, res_zero, res_rd);
        end
        n_checks++;
        if ({alu_s, alu_x, alu_y} !== {4'd1, 32'd0, 32'd0}) begin
            n_fail++; $display("FAIL illegal alu hold: s=%0d x=%h y=%h required 1 0 0", alu_s, alu_x, alu_y);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_checks++;
        if ({res_valid, cmd_ready} !== 2'b01) begin
            n_fail++; $display("FAIL illegal handshake: rv=%b cr=%b required 0 1", res_valid, cmd_ready);
        end
        run_cmd("r1_after_illegal", 4'd1, 5'd1, 5'd0, 5'd10, 32'd5, 1'b0);
    endtask

    task automatic test_back_to_back();
        int n;
        cmd_valid = 1'b1; cmd_op = 4'd2; cmd_rs = 5'd1; cmd_rt = 5'd2; cmd_rd = 5'd11;
        tick();
        cmd_op = 4'd6; cmd_rd = 5'd12;
        n = 0;
        while (res_valid !== 1'b1 && n < 20) begin tick(); n++; end
        n_checks++;
        if (n != ALU_LAT + 1) begin
            n_fail++; $display("FAIL b2b latency: got %0d edges required %0d", n, ALU_LAT + 1);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({res_valid, res_data, res_err, res_rd, cmd_ready} !== {1'b1, 32'd8, 1'b0, 5'd11, 1'b0}) begin
                n_fail++; $display("FAIL b2b hold %0d: rv=%b data=%h err=%b rd=%0d cr=%b required 1 8 0 11 0",
                                   i, res_valid, res_data, res_err, res_rd, cmd_ready);
            end
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_checks++;
        if ({res_valid, cmd_ready} !== 2'b01) begin
            n_fail++; $display("FAIL b2b release: rv=%b cr=%b required 0 1", res_valid, cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b second accept: cmd_ready=%b required 0", cmd_ready);
        end
        n = 0;
        while (res_valid !== 1'b1 && n < 20) begin tick(); n++; end
        n_checks++;
        if ({n == ALU_LAT + 1, res_data, res_rd} !== {1'b1, 32'd2, 5'd12}) begin
            n_fail++; $display("FAIL b2b second result: edges=%0d data=%h rd=%0d required %0d 2 12",
                               n, res_data, res_rd, ALU_LAT + 1);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_ld_collision();
        ld_en = 1'b1; ld_addr = 5'd1; ld_data = 32'd9;
        run_cmd("ld_same_edge", 4'd1, 5'd1, 5'd0, 5'd13, 32'd5, 1'b0);
        run_cmd("r1_after_ld", 4'd1, 5'd1, 5'd0, 5'd14, 32'd9, 1'b0);
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_op = 4'd2; cmd_rs = 5'd1; cmd_rt = 5'd2; cmd_rd = 5'd15;
        tick();
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({alu_x, alu_y, alu_s, res_valid, res_data, res_zero, res_err, res_rd, cmd_ready} !== '0) begin
            n_fail++; $display("FAIL mid reset outputs: x=%h y=%h s=%h rv=%b cr=%b required all 0",
                               alu_x, alu_y, alu_s, res_valid, cmd_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid reset ready: cmd_ready=%b required 1", cmd_ready);
        end
        run_cmd("r1_cleared", 4'd1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
        run_cmd("r15_no_wb", 4'd1, 5'd15, 5'd0, 5'd4, 32'd0, 1'b1);
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_op = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; res_ready = 1'b0;
        test_reset();
        test_basic();
        test_alu_ops();
        test_r0();
        test_illegal();
        test_back_to_back();
        test_ld_collision();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
